// File: rtl/afifo_wr_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
package afifo_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Width of a requester index; at least one bit even for degenerate counts.
  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/afifo_wr_arb_if.sv
// Requester/FIFO-facing bundle of the write arbiter. With AFIFO_WR_ARB_TAG_EN
// defined, wdata carries the owner index above the payload.
interface afifo_wr_arb_if #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8
);
  localparam int IDW = afifo_pkg::idw(NREQ);
`ifdef AFIFO_WR_ARB_TAG_EN
  localparam int WDW = DSIZE + IDW;
`else
  localparam int WDW = DSIZE;
`endif

  logic [NREQ-1:0]       req;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       gnt;
  logic                  wfull;
  logic [WDW-1:0]        wdata;
  logic                  winc;
  logic [IDW-1:0]        owner;
  logic                  busy;

  modport master (
    input  req, req_data, req_last, wfull,
    output gnt, wdata, winc, owner, busy
  );

  modport slave (
    output req, req_data, req_last, wfull,
    input  gnt, wdata, winc, owner, busy
  );

endinterface

// File: rtl/afifo_wr_arb_rr_pick.sv
// Cyclic priority search over req starting at ptr; purely combinational.
module rr_pick
  import afifo_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = idw(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            found,
  output logic [IDW-1:0]  idx
);

  int j;

  // Walk offsets from farthest to nearest so the nearest match wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NREQ;
      if (req[j]) begin
        found = 1'b1;
        idx   = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/afifo_wr_arb.sv
// Round-robin burst arbiter in front of the async FIFO write port.
// Optional owner tagging of wdata via AFIFO_WR_ARB_TAG_EN.
module afifo_wr_arb
  import afifo_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8,
  parameter int BURST = 4
) (
  input  logic           wclk,
  input  logic           wrst_n,
  afifo_wr_arb_if.master bus
);

  localparam int IDW = idw(NREQ);
  localparam int BCW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [BCW-1:0] LAST_CNT = BCW'(BURST - 1);
  localparam logic [IDW-1:0] MAX_IDX  = IDW'(NREQ - 1);

  arb_state_e       state_reg, state_next;
  logic [IDW-1:0]   owner_reg, owner_next;
  logic [IDW-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [BCW-1:0]   beat_cnt_reg, beat_cnt_next;
  logic             pick_found;
  logic [IDW-1:0]   pick_idx;
  logic             beat;
  logic [DSIZE-1:0] data_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign data_arr[gi] = bus.req_data[gi*DSIZE +: DSIZE];
    end
  endgenerate

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (bus.req),
    .ptr   (rr_ptr_reg),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_reg    <= IDLE;
      owner_reg    <= '0;
      rr_ptr_reg   <= '0;
      beat_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      rr_ptr_reg   <= rr_ptr_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end

  // gnt derives from the async-reset state, so it drops as soon as wrst_n falls.
  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    rr_ptr_next   = rr_ptr_reg;
    beat_cnt_next = beat_cnt_reg;
    beat          = 1'b0;
    bus.gnt       = '0;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          state_next    = BUSY;
          owner_next    = pick_idx;
          beat_cnt_next = '0;
        end
      end
      BUSY: begin
        bus.gnt[owner_reg] = !bus.wfull;
        beat = !bus.wfull && bus.req[owner_reg];
        if (beat) begin
          beat_cnt_next = beat_cnt_reg + 1'b1;
          if (bus.req_last[owner_reg] || (beat_cnt_reg == LAST_CNT)) begin
            state_next    = IDLE;
            beat_cnt_next = '0;
            rr_ptr_next   = (owner_reg == MAX_IDX) ? '0 : owner_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.winc  = beat;
  assign bus.busy  = (state_reg == BUSY);
  assign bus.owner = owner_reg;

`ifdef AFIFO_WR_ARB_TAG_EN
  assign bus.wdata = {owner_reg, data_arr[owner_reg]};
`else
  assign bus.wdata = data_arr[owner_reg];
`endif

endmodule
